// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// Operands are split into NGRP = WIDTH/GROUP lookahead groups. A beat is captured into
// stage 0 on acceptance; stage k resolves group k from its registered group carry-in and
// hands the group carry-out to stage k+1. Result flags are registered after the last group.
// Latency is NGRP cycles and throughput is one beat per cycle. A single global stall holds
// every stage while the output is valid but not accepted.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub        operands; sub=1 computes a - b and ignores cin
//   out_valid / out_ready result beat handshake
//   sum, cout, ovf        result, carry out of MSB (1 = no borrow in sub), signed overflow
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NGRP = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end

    // Stage k keeps only the operand-B bits it still needs (groups k..NGRP-1), so the
    // B skew chain is a triangle. All stages are packed into one flat vector; boff(k)
    // is the offset of stage k's slice.
    function automatic int unsigned boff(input int unsigned k);
        return (k == 0) ? 0 : GROUP * (k * NGRP - (k * (k - 1)) / 2);
    endfunction

    localparam int unsigned BTOT = boff(NGRP);

    // Full lookahead: every carry is a flat sum of products of g/p and the group carry-in.
    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                   input logic [GROUP-1:0] p,
                                                   input logic             ci);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= int'(GROUP); i++) begin
            term = ci;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // acc_q[k]: groups below k hold finished sum bits, groups k and up hold operand A.
    logic [NGRP-1:0]            vld_q, vld_d;
    logic [NGRP-1:0]            c_q, c_d;
    logic [NGRP-1:0][WIDTH-1:0] acc_q, acc_d;
    logic [BTOT-1:0]            b_q, b_d;
    logic [NGRP-1:0][GROUP-1:0] grp_a, grp_b, grp_p, grp_s;
    logic [NGRP-1:0][GROUP:0]   grp_c;
    logic [WIDTH-1:0]           sum_d;
    logic                       advance;
    logic                       out_valid_q, cout_q, ovf_q;
    logic [WIDTH-1:0]           sum_q;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        localparam int unsigned BO = boff(k);
        localparam int unsigned BW = WIDTH - k * GROUP;

        assign grp_a[k] = acc_q[k][k*GROUP +: GROUP];
        assign grp_b[k] = b_q[BO +: GROUP];
        assign grp_p[k] = grp_a[k] ^ grp_b[k];
        assign grp_c[k] = cla_carries(grp_a[k] & grp_b[k], grp_p[k], c_q[k]);
        assign grp_s[k] = grp_p[k] ^ grp_c[k][GROUP-1:0];

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; cin only matters in add mode.
            assign vld_d[0]          = in_valid;
            assign c_d[0]            = sub | cin;
            assign acc_d[0]          = a;
            assign b_d[BO +: WIDTH]  = sub ? ~b : b;
        end else begin : g_next
            localparam int unsigned BOP = boff(k - 1);
            localparam logic [WIDTH-1:0] GMASK =
                {{(WIDTH - GROUP){1'b0}}, {GROUP{1'b1}}} << ((k - 1) * GROUP);

            assign vld_d[k]      = vld_q[k-1];
            assign c_d[k]        = grp_c[k-1][GROUP];
            assign acc_d[k]      = (acc_q[k-1] & ~GMASK) |
                                   ({{(WIDTH - GROUP){1'b0}}, grp_s[k-1]} << ((k - 1) * GROUP));
            assign b_d[BO +: BW] = b_q[BOP + GROUP +: BW];
        end
    end

    if (NGRP == 1) begin : g_sum_one
        assign sum_d = grp_s[0];
    end else begin : g_sum_many
        assign sum_d = {grp_s[NGRP-1], acc_q[NGRP-1][WIDTH-GROUP-1:0]};
    end

    assign advance  = !out_valid_q | out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            vld_q       <= vld_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            out_valid_q <= vld_q[NGRP-1];
            sum_q       <= sum_d;
            cout_q      <= grp_c[NGRP-1][GROUP];
            // Overflow: carry into the MSB differs from carry out of it.
            ovf_q       <= grp_c[NGRP-1][GROUP] ^ grp_c[NGRP-1][GROUP-1];
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
// Expected results are queued when a beat is accepted and compared when it leaves.
module tb_cla_pipe_adder;
    localparam int W    = 16;
    localparam int G    = 4;
    localparam int NGRP = W / G;
    localparam int NVEC = 12;

    logic         clk, rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W+1:0] res;      // {cout, ovf, sum}
        int           acc_cyc;
    } exp_t;

    vec_t         vecs [NVEC];
    exp_t         exp_q [$];
    int           errors = 0;
    int           checks = 0;
    int           pops   = 0;
    int           cyc    = 0;
    logic         check_lat;
    logic         done;
    logic [W+1:0] cur_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: plain integer addition plus the sign rule for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         v;
        be = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
        v  = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
        return {r[W], v, r[W-1:0]};
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                check("reset_out_valid", {17'b0, out_valid}, '0);
            end else begin
                if (out_valid && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got sum %h, required no beat", sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {cout, ovf, sum}, e.res);
                        if (check_lat) check("latency", 18'(cyc - e.acc_cyc), 18'(NGRP));
                    end
                end else if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_held: got sum %h, required no beat", sum);
                    end else begin
                        check("held_result", {cout, ovf, sum}, exp_q[0].res);
                    end
                end
                if (in_valid && in_ready) begin
                    e.res     = cur_exp;
                    e.acc_cyc = cyc + 1;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input logic ts, input logic [W+1:0] te);
        bit took;
        a        = ta;
        b        = tbv;
        cin      = tc;
        sub      = ts;
        cur_exp  = te;
        in_valid = 1'b1;
        took     = 1'b0;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk);
            took = in_ready && rst_n;
            @(posedge clk);
            #1;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required acceptance");
        end
    endtask

    task automatic send_rand();
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, 18'(exp_q.size()), '0);
    endtask

    initial begin
        int p0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        check_lat = 1'b0;
        done      = 1'b0;
        cur_exp   = '0;

        //          a         b         cin   sub   sum       cout  ovf
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h5555, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {cout, ovf, sum}, '0);
        check("reset_out_valid_hand", {17'b0, out_valid}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {17'b0, in_ready}, 18'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back, fixed latency
        check_lat = 1'b1;
        for (int i = 0; i < NVEC; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 {vecs[i].cout, vecs[i].ovf, vecs[i].sum});
        idle(1);
        drain("table");

        // Backpressure: 6 beats, out_ready low across 4 edges once the pipe is full
        check_lat = 1'b0;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W'(i), W'(256 * i), 1'b0, 1'b0, {2'b00, W'(257 * i)});
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    check("stall_in_ready", {17'b0, in_ready}, '0);
                    check("stall_out_valid", {17'b0, out_valid}, 18'd1);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("transfer_count", 18'(pops - p0), 18'd6);

        // Bubbles: alternate valid/idle, latency must stay NGRP
        check_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send_rand();
            else idle(1);
        end
        idle(1);
        drain("bubbles");

        // Random operands under random backpressure
        check_lat = 1'b0;
        done      = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_rand();
                in_valid = 1'b0;
                done     = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("random");

        // Reset with 3 beats in flight and the first one held at the output
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        idle(5);
        check("pre_reset_out_valid", {17'b0, out_valid}, 18'd1);
        rst_n = 1'b0;
        #2;
        check("async_reset_out_valid", {17'b0, out_valid}, '0);
        check("async_reset_result", {cout, ovf, sum}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(8);
        check("post_reset_no_stale", 18'(pops - p0 - 6 - 4 - 20), '0);
        check_lat = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h0000});
        idle(1);
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Operands are split into GROUP-bit CLA groups. Each group uses generate/propagate (Gi = ai&bi, Pi = ai^bi) with full lookahead inside the group.
- Inter-group carry is registered, so each pipeline stage resolves one group. Stage 0 resolves the least-significant group, stage NGRP-1 the most-significant.
- Sits between an operand source and result consumer on valid/ready streams; it is the datapath adder for wider ALU work.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP (elaboration error otherwise)
GROUP, 4, bits per CLA group; NGRP = WIDTH/GROUP = number of pipeline stages

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  1 = compute a - b, 0 = a + b + cin
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (in sub mode, 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All registers clear on assertion; release is sampled synchronously.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, all stage valid bits=0. in_ready=1 one cycle after reset release.
- Operand conditioning at stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin. cin is ignored when sub=1.
- Stage k (k = 0..NGRP-1):
  - Computes group k sum bits and group carry-out from the registered group carry-in.
  - Uses full lookahead, with no ripple inside the group.
  - Group P = AND of Pi; group G = standard lookahead term.
  - Group carry-out = G | (P & cin_k).
- Skew and de-skew:
  - Upper operand groups (k+1..NGRP-1) ride along a skew register chain.
  - Already-computed lower sum groups ride along a de-skew chain.
  - sum is presented fully aligned at the output.
- Latency: a beat accepted at edge T appears with out_valid=1 after edge T+NGRP (4 cycles for defaults). Throughput is 1 beat/cycle when unstalled.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - When advance=0, every stage holds. sum/cout/ovf/out_valid stay stable until accepted.
  - Bubbles (in_valid=0 while advancing) propagate as invalid stages. Results are never reordered, duplicated or dropped.
  - in_ready does not depend combinationally on in_valid. in_ready is combinational from out_ready (single global stall).
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Boundary cases:
  - NGRP=1: degenerates to one registered CLA stage with latency 1.
  - A full carry chain (e.g. all-ones + 1) must resolve correctly across every stage boundary.
  - out_ready low while the pipe is full: no beat lost, in_ready=0.
  - Simultaneous input accept and output accept on a full pipe: both happen in the same cycle.
  - Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (asynchronous). No partial result appears after release.
  - sub and cin are captured with their beat; changing them while in_ready=0 has no effect.

Test Plan:
- Carry chain: WIDTH=16; a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. out_valid is first seen exactly 4 cycles after the accept edge.
- Signed overflow (add): a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0, ovf=0.
- Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0. cin is toggled during these beats and must have no effect.
- Backpressure: stream 6 beats (i, 0x0100*i) for i=0..5 back-to-back, with out_ready=0 for cycles 5-8.
  - in_ready=0 while stalled.
  - Held result stays stable.
  - All 6 results emerge in order with correct sums.
  - Total transfer count is 6.
- Bubbles: alternate in_valid 1/0 for 8 cycles with out_ready=1 -> results appear with the same 1/0 spacing and latency 4.
- Reset: pulse rst_n low mid-stream with 3 beats in flight -> out_valid=0 during reset, no stale beat after release, and the next accepted beat completes normally.
